// File: rtl/mdio_master_if.sv
// rtl/mdio_master_if.sv - request/response bundle between a PHY management client and mdio_master
//
// Ports (signals):
//   req_valid/req_ready   request handshake, accepted on a clk edge with both high
//   req_op                0 = write, 1 = read
//   req_phy/req_reg       5-bit PHY and register addresses
//   req_wdata             16-bit write data
//   rsp_valid             one-cycle pulse at frame completion
//   rsp_rdata/rsp_err     read data and turnaround error, valid with rsp_valid
//   busy                  frame in progress
// Modports: master = requester (sequencer / CPU side), slave = mdio_master.

interface mdio_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [4:0]  req_phy;
    logic [4:0]  req_reg;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    modport master (
        output req_valid, req_op, req_phy, req_reg, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_op, req_phy, req_reg, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/mdio_master.sv
// rtl/mdio_master.sv - IEEE 802.3 Clause 22 MDIO management master, one frame per request
//
// Ports:
//   clk      system clock
//   rst      asynchronous reset, active-high
//   bus      mdio_master_if.slave: request/response handshake, busy
//   mdc      management clock, half-period CLK_DIV clk cycles, low when idle
//   mdio_o   MDIO output value
//   mdio_oe  MDIO output enable (1 = drive)
//   mdio_i   MDIO input, sampled on the clk edge where mdc rises
// Parameters:
//   CLK_DIV  mdc half-period in clk cycles (>= 1)
//   PRE_LEN  preamble length in bits (0..63, 0 = preamble suppressed)

module mdio_master #(
    parameter int CLK_DIV = 4,
    parameter int PRE_LEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    mdio_master_if.slave    bus,
    output logic            mdc,
    output logic            mdio_o,
    output logic            mdio_oe,
    input  logic            mdio_i
);

    localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [5:0]        PRE_LAST = 6'(PRE_LEN - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_ST, S_OP, S_PHY, S_REG, S_TA, S_DATA, S_END
    } state_t;

    state_t             state_q, state_d;
    logic [5:0]         bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic               mdc_q, mdc_d;
    logic               mdio_o_q, mdio_o_d;
    logic               mdio_oe_q, mdio_oe_d;
    logic               op_q, op_d;
    logic [4:0]         phy_q, phy_d;
    logic [4:0]         reg_q, reg_d;
    logic [15:0]        wdata_q, wdata_d;
    logic [15:0]        shift_q, shift_d;
    logic               ta_err_q, ta_err_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [15:0]        rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;

    // Bit count (minus one) of each field; the counter is reloaded with this
    // on entry to the field and counts down to zero, which doubles as the
    // MSB-first bit index.
    function automatic logic [5:0] field_last(state_t s);
        case (s)
            S_PRE:              return PRE_LAST;
            S_ST, S_OP, S_TA:   return 6'd1;
            S_PHY, S_REG:       return 6'd4;
            S_DATA:             return 6'd15;
            default:            return 6'd0;
        endcase
    endfunction

    function automatic state_t next_field(state_t s);
        case (s)
            S_PRE:   return S_ST;
            S_ST:    return S_OP;
            S_OP:    return S_PHY;
            S_PHY:   return S_REG;
            S_REG:   return S_TA;
            S_TA:    return S_DATA;
            S_DATA:  return S_END;
            default: return S_IDLE;
        endcase
    endfunction

    // {oe, o} for bit 'cnt' of field 's'. Released bits park mdio_o at 1.
    function automatic logic [1:0] bit_drive(state_t s, logic [5:0] cnt, logic op,
                                             logic [4:0] phy, logic [4:0] rg,
                                             logic [15:0] wd);
        logic [4:0]  phy_sh;
        logic [4:0]  reg_sh;
        logic [15:0] wd_sh;
        phy_sh = phy >> cnt;
        reg_sh = rg >> cnt;
        wd_sh  = wd >> cnt;
        case (s)
            S_PRE:   return 2'b11;
            S_ST:    return {1'b1, cnt == 6'd0};
            S_OP:    return {1'b1, op ? (cnt == 6'd1) : (cnt == 6'd0)};
            S_PHY:   return {1'b1, phy_sh[0]};
            S_REG:   return {1'b1, reg_sh[0]};
            S_TA:    return op ? 2'b01 : {1'b1, cnt == 6'd1};
            S_DATA:  return op ? 2'b01 : {1'b1, wd_sh[0]};
            default: return 2'b01;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        div_cnt_d   = div_cnt_q;
        mdc_d       = mdc_q;
        mdio_o_d    = mdio_o_q;
        mdio_oe_d   = mdio_oe_q;
        op_d        = op_q;
        phy_d       = phy_q;
        reg_d       = reg_q;
        wdata_d     = wdata_q;
        shift_d     = shift_q;
        ta_err_d    = ta_err_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        if (state_q == S_IDLE) begin
            mdc_d = 1'b0;
            if (bus.req_valid) begin
                // The first bit starts on the accepting edge itself.
                op_d      = bus.req_op;
                phy_d     = bus.req_phy;
                reg_d     = bus.req_reg;
                wdata_d   = bus.req_wdata;
                shift_d   = 16'h0000;
                ta_err_d  = 1'b0;
                div_cnt_d = '0;
                state_d   = (PRE_LEN > 0) ? S_PRE : S_ST;
                bit_cnt_d = field_last(state_d);
                {mdio_oe_d, mdio_o_d} = bit_drive(state_d, bit_cnt_d, bus.req_op,
                                                  bus.req_phy, bus.req_reg, bus.req_wdata);
            end
        end else if (div_cnt_q != DIV_LAST) begin
            div_cnt_d = div_cnt_q + 1'b1;
        end else begin
            div_cnt_d = '0;
            if (!mdc_q) begin
                // Rising mdc: sample point for read turnaround and data.
                mdc_d = 1'b1;
                if (op_q && state_q == S_TA && bit_cnt_q == 6'd0) begin
                    ta_err_d = mdio_i;
                end
                if (op_q && state_q == S_DATA) begin
                    shift_d = {shift_q[14:0], mdio_i};
                end
            end else begin
                // Falling mdc: bit boundary.
                mdc_d = 1'b0;
                if (bit_cnt_q != 6'd0) begin
                    bit_cnt_d = bit_cnt_q - 6'd1;
                end else begin
                    state_d   = next_field(state_q);
                    bit_cnt_d = field_last(state_d);
                end
                if (state_d == S_IDLE) begin
                    mdio_oe_d   = 1'b0;
                    mdio_o_d    = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = op_q ? shift_q : 16'h0000;
                    rsp_err_d   = op_q & ta_err_q;
                end else begin
                    {mdio_oe_d, mdio_o_d} = bit_drive(state_d, bit_cnt_d, op_q,
                                                      phy_q, reg_q, wdata_q);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 6'd0;
            div_cnt_q   <= '0;
            mdc_q       <= 1'b0;
            mdio_o_q    <= 1'b1;
            mdio_oe_q   <= 1'b0;
            op_q        <= 1'b0;
            phy_q       <= 5'd0;
            reg_q       <= 5'd0;
            wdata_q     <= 16'h0000;
            shift_q     <= 16'h0000;
            ta_err_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 16'h0000;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            div_cnt_q   <= div_cnt_d;
            mdc_q       <= mdc_d;
            mdio_o_q    <= mdio_o_d;
            mdio_oe_q   <= mdio_oe_d;
            op_q        <= op_d;
            phy_q       <= phy_d;
            reg_q       <= reg_d;
            wdata_q     <= wdata_d;
            shift_q     <= shift_d;
            ta_err_q    <= ta_err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign mdc           = mdc_q;
    assign mdio_o        = mdio_o_q;
    assign mdio_oe       = mdio_oe_q;

endmodule

// File: tb/tb_mdio_master.sv
// tb/tb_mdio_master.sv - randomized self-checking bench for mdio_master (two parameter sets)

module tb_mdio_master;

    typedef struct packed {
        bit        op;
        bit [4:0]  phy;
        bit [4:0]  rg;
        bit [15:0] wdata;
        bit        ta2;
        bit [15:0] pdata;
    } req_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        mdio_i;
    logic        req_valid;
    logic        req_op;
    logic [4:0]  req_phy;
    logic [4:0]  req_reg;
    logic [15:0] req_wdata;

    logic mdc_a, mdo_a, oe_a, mdc_b, mdo_b, oe_b;
    logic m_mdc, m_o, m_oe, m_ready, m_busy, m_rv, m_err;
    logic [15:0] m_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    bit eo[$];
    bit eoe[$];

    always #5 clk = ~clk;

    mdio_master_if if_a ();
    mdio_master_if if_b ();

    assign if_a.req_valid = req_valid & ~sel;
    assign if_a.req_op    = req_op;
    assign if_a.req_phy   = req_phy;
    assign if_a.req_reg   = req_reg;
    assign if_a.req_wdata = req_wdata;
    assign if_b.req_valid = req_valid & sel;
    assign if_b.req_op    = req_op;
    assign if_b.req_phy   = req_phy;
    assign if_b.req_reg   = req_reg;
    assign if_b.req_wdata = req_wdata;

    mdio_master #(.CLK_DIV(2), .PRE_LEN(32)) u_dut_a (
        .clk(clk), .rst(rst), .bus(if_a.slave),
        .mdc(mdc_a), .mdio_o(mdo_a), .mdio_oe(oe_a), .mdio_i(mdio_i)
    );

    mdio_master #(.CLK_DIV(1), .PRE_LEN(0)) u_dut_b (
        .clk(clk), .rst(rst), .bus(if_b.slave),
        .mdc(mdc_b), .mdio_o(mdo_b), .mdio_oe(oe_b), .mdio_i(mdio_i)
    );

    assign m_mdc   = sel ? mdc_b : mdc_a;
    assign m_o     = sel ? mdo_b : mdo_a;
    assign m_oe    = sel ? oe_b  : oe_a;
    assign m_ready = sel ? if_b.req_ready : if_a.req_ready;
    assign m_busy  = sel ? if_b.busy      : if_a.busy;
    assign m_rv    = sel ? if_b.rsp_valid : if_a.rsp_valid;
    assign m_rdata = sel ? if_b.rsp_rdata : if_a.rsp_rdata;
    assign m_err   = sel ? if_b.rsp_err   : if_a.rsp_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic req_t rand_req(input bit op);
        req_t r;
        r.op    = op;
        r.phy   = 5'($urandom);
        r.rg    = 5'($urandom);
        r.wdata = 16'($urandom);
        r.ta2   = ($urandom_range(0, 3) == 0);
        r.pdata = 16'($urandom);
        return r;
    endfunction

    task automatic drive(input req_t r);
        req_op    = r.op;
        req_phy   = r.phy;
        req_reg   = r.rg;
        req_wdata = r.wdata;
    endtask

    task automatic push_bit(input bit o, input bit oe);
        eo.push_back(o);
        eoe.push_back(oe);
    endtask

    // Reference frame: expected bit stream from the Clause 22 field layout,
    // PHY model driving mdio_i, and the expected response.
    task automatic check_frame(input req_t r);
        int cd, pre, nb, n, b, mdc_e, bus_e, st_e;
        bit [15:0] er;
        bit ee;
        cd  = sel ? 1 : 2;
        pre = sel ? 0 : 32;
        eo.delete();
        eoe.delete();
        for (int i = 0; i < pre; i++) push_bit(1'b1, 1'b1);
        push_bit(1'b0, 1'b1);
        push_bit(1'b1, 1'b1);
        push_bit(r.op, 1'b1);
        push_bit(!r.op, 1'b1);
        for (int i = 4; i >= 0; i--) push_bit(r.phy[i], 1'b1);
        for (int i = 4; i >= 0; i--) push_bit(r.rg[i], 1'b1);
        if (r.op) begin
            for (int i = 0; i < 18; i++) push_bit(1'b1, 1'b0);
        end else begin
            push_bit(1'b1, 1'b1);
            push_bit(1'b0, 1'b1);
            for (int i = 15; i >= 0; i--) push_bit(r.wdata[i], 1'b1);
        end
        push_bit(1'b1, 1'b0);
        nb = eo.size();
        n  = nb * 2 * cd;
        mdc_e = 0; bus_e = 0; st_e = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            b = k / (2 * cd);
            if (r.op && b == pre + 15)
                mdio_i = r.ta2;
            else if (r.op && b >= pre + 16 && b < pre + 32)
                mdio_i = r.pdata[15 - (b - pre - 16)];
            else
                mdio_i = 1'b1;
            if (m_mdc !== ((k % (2 * cd)) >= cd)) mdc_e++;
            if (m_oe !== eoe[b]) bus_e++;
            if ((eoe[b] || b == nb - 1) && m_o !== eo[b]) bus_e++;
            if (m_busy !== 1'b1 || m_ready !== 1'b0 || m_rv !== 1'b0) st_e++;
        end
        mdio_i = 1'b1;
        @(negedge clk);
        er = r.op ? r.pdata : 16'h0000;
        ee = r.op ? r.ta2 : 1'b0;
        check("mdc_waveform_errs", mdc_e, 0);
        check("mdio_bit_errs", bus_e, 0);
        check("busy_ready_errs", st_e, 0);
        check("rsp_valid", m_rv, 1);
        check("rsp_rdata", m_rdata, er);
        check("rsp_err", m_err, ee);
        check("ready_in_rsp", m_ready, 1);
        check("busy_in_rsp", m_busy, 0);
        check("mdio_oe_idle", m_oe, 0);
    endtask

    // Entered at a negedge with r on the request pins and req_valid high.
    task automatic run_req(input req_t r, input bit has_next, input req_t nx, input bit expect_now);
        int w;
        w = 0;
        while (!m_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("accept_ready", m_ready, 1);
        if (expect_now) check("b2b_accept_wait", w, 0);
        @(posedge clk);
        #1;
        if (has_next) begin
            drive(nx);
        end else begin
            req_valid = 1'b0;
            drive(rand_req(1'($urandom)));
        end
        check_frame(r);
    endtask

    task automatic post_idle(input logic [15:0] held);
        @(negedge clk);
        check("rsp_valid_pulse", m_rv, 0);
        check("rdata_hold", m_rdata, held);
    endtask

    task automatic single(input req_t r);
        req_t dummy;
        dummy = r;
        drive(r);
        req_valid = 1'b1;
        run_req(r, 1'b0, dummy, 1'b0);
        post_idle(r.op ? r.pdata : 16'h0000);
    endtask

    task automatic pair(input req_t r1, input req_t r2);
        drive(r1);
        req_valid = 1'b1;
        run_req(r1, 1'b1, r2, 1'b0);
        run_req(r2, 1'b0, r1, 1'b1);
        post_idle(r2.op ? r2.pdata : 16'h0000);
    endtask

    task automatic mid_reset();
        req_t r;
        int seen;
        r = rand_req(1'b1);
        drive(r);
        req_valid = 1'b1;
        while (!m_ready) @(negedge clk);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int k = 0; k < (32 + 20) * 4 + 1; k++) begin
            @(negedge clk);
            mdio_i = 1'($urandom);
        end
        #2;
        rst = 1'b1;
        #1;
        check("rst_mdc", m_mdc, 0);
        check("rst_oe", m_oe, 0);
        check("rst_o", m_o, 1);
        check("rst_busy", m_busy, 0);
        check("rst_ready", m_ready, 1);
        check("rst_rsp_valid", m_rv, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mdio_i = 1'b1;
        seen = 0;
        repeat (300) begin
            @(negedge clk);
            if (m_rv) seen++;
        end
        check("rst_no_rsp", seen, 0);
    endtask

    initial begin
        req_t r;
        rst       = 1'b1;
        sel       = 1'b0;
        mdio_i    = 1'b1;
        req_valid = 1'b0;
        drive(rand_req(1'b0));
        repeat (3) @(posedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            @(negedge clk);
            check("reset_mdc", m_mdc, 0);
            check("reset_oe", m_oe, 0);
            check("reset_o", m_o, 1);
            check("reset_ready", m_ready, 1);
            check("reset_busy", m_busy, 0);
            check("reset_rsp_valid", m_rv, 0);
            check("reset_rdata", m_rdata, 0);
            check("reset_err", m_err, 0);
        end
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        r = '{op: 1'b0, phy: 5'h10, rg: 5'd0, wdata: 16'h8140, ta2: 1'b0, pdata: 16'h0};
        single(r);
        r = '{op: 1'b1, phy: 5'h10, rg: 5'd2, wdata: 16'h0, ta2: 1'b0, pdata: 16'h0141};
        single(r);
        r = '{op: 1'b1, phy: 5'h05, rg: 5'd1, wdata: 16'h0, ta2: 1'b1, pdata: 16'hFFFF};
        single(r);
        pair(rand_req(1'b0), rand_req(1'b1));
        for (int i = 0; i < 4; i++) single(rand_req(1'($urandom)));
        mid_reset();
        single(rand_req(1'b1));

        sel = 1'b1;
        @(negedge clk);
        single(rand_req(1'b0));
        single(rand_req(1'b1));
        pair(rand_req(1'b1), rand_req(1'b0));
        for (int i = 0; i < 4; i++) single(rand_req(1'($urandom)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mdio_master.md
Name: mdio_master

Overview:
- Parametrised IEEE 802.3 Clause 22 MDIO management master. Performs one read or write frame per request on a request/response handshake.
- Generates MDC from the system clock and drives MDIO through split out/oe/in pins. The pad-level tristate buffer lives outside this block.
- Sits between a PHY configuration sequencer or CPU register bank and the external PHY management pins. It is the general successor to the fixed-table, write-only PHY init engine.

Parameters:
- CLK_DIV, 4, MDC half-period in clk cycles; legal range ≥1. One MDIO bit time = 2*CLK_DIV clk cycles.
- PRE_LEN, 32, number of preamble '1' bits; legal range 0..63. 0 = preamble suppression.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_op  in  1  0 = write, 1 = read
- req_phy  in  5  PHY address
- req_reg  in  5  register address
- req_wdata  in  16  write data
- rsp_valid  out  1  one-cycle pulse: frame complete
- rsp_rdata  out  16  read data; valid with rsp_valid
- rsp_err  out  1  read turnaround error; valid with rsp_valid
- busy  out  1  frame in progress
- mdc  out  1  management clock
- mdio_o  out  1  MDIO output value
- mdio_oe  out  1  MDIO output enable (1 = drive)
- mdio_i  in  1  MDIO input

Behaviour:
- Reset (asynchronous, immediate, including mid-frame): state IDLE, mdc=0, mdio_oe=0, mdio_o=1, req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. The frame is abandoned; no rsp_valid is issued for it.
- Handshake: a request is accepted on a clk edge with req_valid && req_ready. op/phy/reg/wdata are captured internally on that edge, so inputs may change afterwards. req_ready=0 and busy=1 from the next cycle until the frame ends.
- Bit timing:
  - Each bit begins with mdc low; mdio_o/mdio_oe are updated on that same edge.
  - mdc is low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - mdio_i is sampled on the edge where mdc goes 0→1.
  - mdc=0 whenever IDLE.
- States and bits, all fields MSB first:
  - PRE: PRE_LEN bits of '1', oe=1. Skipped when PRE_LEN=0.
  - ST: 0,1.
  - OP: write 0,1; read 1,0.
  - PHY: 5 bits.
  - REG: 5 bits.
  - TA, write: drive 1,0.
  - TA, read: oe=0 for both bits; the second TA sample must be 0, otherwise the error flag is set.
  - DATA, write: drive 16 bits of wdata.
  - DATA, read: oe=0; shift in 16 samples MSB first.
  - END: one bit time with oe=0, mdio_o=1, mdc toggling normally.
  - IDLE.
- Latency: with acceptance at edge T, rsp_valid=1 in the cycle after edge T+(PRE_LEN+33)*2*CLK_DIV. The state returns to IDLE on that same edge, so req_ready=1 in the rsp_valid cycle and a back-to-back request can be accepted then.
- Response on a write: rsp_rdata=0, rsp_err=0.
- Response on a read: rsp_rdata = shifted samples; rsp_err = (TA2 sample == 1). The frame always runs to completion even on error.
- rsp_rdata/rsp_err hold their values until the next rsp_valid.
- Bit counter: 6 bits wide, reloaded at each field boundary. No wrap into the next field.
- CLK_DIV=1: mdc toggles every clk cycle; sampling rules are unchanged.

Test Plan:
- Write, CLK_DIV=2, PRE_LEN=32: phy=0x10, reg=0, wdata=0x8140 accepted at T.
  - Bus: 32×'1' then 01 01 10000 00000 10 1000000101000000, oe=1 throughout these bits.
  - END: oe=0.
  - Response: rsp_valid at T+261 with rdata=0, err=0; mdc period is 4 cycles.
- Read, CLK_DIV=2: phy=0x10, reg=2; PHY model drives TA2=0 then 0x0141 on sampled edges.
  - Bus: OP=10, oe=0 from the first TA bit.
  - Response: rsp_valid at T+261 with rdata=0x0141, err=0.
- Read with no PHY (mdio_i tied to 1) -> err=1, rdata=0xFFFF; the frame completes with normal latency.
- PRE_LEN=0, CLK_DIV=2, write -> the first driven bits are ST 0,1 immediately; rsp_valid at T+133.
- Back-to-back with req_valid held high for a write then a read -> the second request is accepted in the first frame's rsp_valid cycle, and the second frame's PRE starts on the next edge.
- rst asserted during a read's DATA field -> mdc=0, oe=0, mdio_o=1, busy=0, req_ready=1 immediately with no rsp_valid. A new request after release produces a normal frame.
